// File: rtl/frame_req_pkg.sv
// rtl/frame_req_pkg.sv - shared types and TDATA field layout for frame_request_gen
// Contents: FSM state enum, row/frame field offsets and widths within TDATA.
package frame_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int ROW_LSB   = 0;
    localparam int ROW_W     = 8;
    localparam int FRAME_LSB = 16;
    localparam int FRAME_W   = 16;

endpackage

// File: rtl/frame_request_gen_rise_detect.sv
// rtl/frame_request_gen_rise_detect.sv - one-flop rising-edge detector for the trigger input
// Ports: clk, reset (sync, active-high), din (level input), rise (high for the cycle
// in which din is 1 and was 0 on the previous clock).
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic armed;

    // armed only becomes 1 once din has been seen low, so a level held high
    // across reset never looks like a fresh edge when reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
            armed <= ~din;
        end else begin
            din_q <= din;
            armed <= armed | ~din;
        end
    end

    assign rise = din & ~din_q & armed;

endmodule

// File: rtl/frame_request_gen.sv
// rtl/frame_request_gen.sv - triggered multi-frame row-request generator on an AXI-Stream master
// Ports: clk, reset (sync, active-high); BUTTON trigger level (rising edge starts a run);
// FRAME_COUNT frames per run (0 = continuous); STOP ends a run at the next frame boundary;
// BUSY run in progress; AXIS_TX_TDATA/TVALID/TLAST/TREADY request stream
// (TDATA[7:0] row, TDATA[31:16] frame, other bits 0).
module frame_request_gen
    import frame_req_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int ROWS_PER_FRAME = 8,
    parameter int FIRST_FRAME    = 12,
    parameter int GAP_CYCLES     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  BUTTON,
    input  logic [7:0]            FRAME_COUNT,
    input  logic                  STOP,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic                  AXIS_TX_TVALID,
    output logic                  AXIS_TX_TLAST,
    input  logic                  AXIS_TX_TREADY
);

    if (DATA_WIDTH < 32 || ROWS_PER_FRAME < 1 || ROWS_PER_FRAME > 256 ||
        GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_param_check
        $error("frame_request_gen: illegal parameter combination");
    end

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS_PER_FRAME - 1);
    localparam logic [7:0]         GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [FRAME_W-1:0] FRAME_INIT = FRAME_W'(FIRST_FRAME);
    localparam logic               ONE_ROW    = (ROWS_PER_FRAME == 1);

    state_t               state, state_n;
    logic [ROW_W-1:0]     row, row_n;
    logic [FRAME_W-1:0]   frame, frame_n;
    logic [7:0]           frames_left, frames_left_n;
    logic                 continuous, continuous_n;
    logic [7:0]           gap_cnt, gap_cnt_n;
    logic                 tvalid, tvalid_n;
    logic                 tlast, tlast_n;
    logic                 busy, busy_n;
    logic                 start;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .din   (BUTTON),
        .rise  (start)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            frame       <= FRAME_INIT;
            frames_left <= '0;
            continuous  <= 1'b0;
            gap_cnt     <= '0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            frame       <= frame_n;
            frames_left <= frames_left_n;
            continuous  <= continuous_n;
            gap_cnt     <= gap_cnt_n;
            tvalid      <= tvalid_n;
            tlast       <= tlast_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n       = state;
        row_n         = row;
        frame_n       = frame;
        frames_left_n = frames_left;
        continuous_n  = continuous;
        gap_cnt_n     = gap_cnt;
        tvalid_n      = tvalid;
        tlast_n       = tlast;
        busy_n        = busy;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n       = SEND;
                    frames_left_n = FRAME_COUNT;
                    continuous_n  = (FRAME_COUNT == 8'd0);
                    row_n         = '0;
                    tvalid_n      = 1'b1;
                    tlast_n       = ONE_ROW;
                    busy_n        = 1'b1;
                end
            end

            SEND: begin
                if (tvalid && AXIS_TX_TREADY) begin
                    if (row != ROW_LAST) begin
                        row_n   = row + 1'b1;
                        tlast_n = (row + 1'b1 == ROW_LAST);
                    end else begin
                        frame_n = frame + 1'b1;
                        row_n   = '0;
                        if (!continuous) begin
                            frames_left_n = frames_left - 1'b1;
                        end
                        if (STOP || (!continuous && frames_left == 8'd1)) begin
                            state_n  = IDLE;
                            tvalid_n = 1'b0;
                            tlast_n  = 1'b0;
                            busy_n   = 1'b0;
                        end else if (GAP_CYCLES == 0) begin
                            tvalid_n = 1'b1;
                            tlast_n  = ONE_ROW;
                        end else begin
                            state_n   = GAP;
                            tvalid_n  = 1'b0;
                            tlast_n   = 1'b0;
                            gap_cnt_n = '0;
                        end
                    end
                end
            end

            GAP: begin
                if (STOP) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_n  = SEND;
                    tvalid_n = 1'b1;
                    tlast_n  = ONE_ROW;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_n  = IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_comb begin
        AXIS_TX_TDATA                        = '0;
        AXIS_TX_TDATA[ROW_LSB +: ROW_W]     = row;
        AXIS_TX_TDATA[FRAME_LSB +: FRAME_W] = frame;
    end

    assign AXIS_TX_TVALID = tvalid;
    assign AXIS_TX_TLAST  = tlast;
    assign BUSY           = busy;

endmodule

// File: tb/tb_frame_request_gen.sv
// tb/tb_frame_request_gen.sv - self-checking bench for frame_request_gen
// Two instances: dut_a with default parameters, dut_g with GAP_CYCLES=2 and FIRST_FRAME=0xFFFF.
module tb_frame_request_gen;

    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, button_a, button_g, stop, tready;
    logic [7:0]    frame_count;
    logic          busy_a, tvalid_a, tlast_a;
    logic          busy_g, tvalid_g, tlast_g;
    logic [DW-1:0] tdata_a, tdata_g;

    frame_request_gen dut_a (
        .clk            (clk),
        .reset          (reset),
        .BUTTON         (button_a),
        .FRAME_COUNT    (frame_count),
        .STOP           (stop),
        .BUSY           (busy_a),
        .AXIS_TX_TDATA  (tdata_a),
        .AXIS_TX_TVALID (tvalid_a),
        .AXIS_TX_TLAST  (tlast_a),
        .AXIS_TX_TREADY (tready)
    );

    frame_request_gen #(
        .FIRST_FRAME (16'hFFFF),
        .GAP_CYCLES  (2)
    ) dut_g (
        .clk            (clk),
        .reset          (reset),
        .BUTTON         (button_g),
        .FRAME_COUNT    (frame_count),
        .STOP           (stop),
        .BUSY           (busy_g),
        .AXIS_TX_TDATA  (tdata_g),
        .AXIS_TX_TVALID (tvalid_g),
        .AXIS_TX_TLAST  (tlast_g),
        .AXIS_TX_TREADY (tready)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    logic          busy_m[2], tvalid_m[2], tlast_m[2];
    logic [DW-1:0] tdata_m[2];
    assign busy_m[0]   = busy_a;
    assign busy_m[1]   = busy_g;
    assign tvalid_m[0] = tvalid_a;
    assign tvalid_m[1] = tvalid_g;
    assign tlast_m[0]  = tlast_a;
    assign tlast_m[1]  = tlast_g;
    assign tdata_m[0]  = tdata_a;
    assign tdata_m[1]  = tdata_g;

    function automatic logic [DW-1:0] beat_data(input int row, input int frame);
        logic [DW-1:0] v;
        v        = '0;
        v[7:0]   = row[7:0];
        v[31:16] = frame[15:0];
        return v;
    endfunction

    function automatic int gap_exp(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic push_frames(input int id, input int first, input int nframes);
        beat_t b;
        for (int f = 0; f < nframes; f++) begin
            for (int r = 0; r < 8; r++) begin
                b.id   = id;
                b.data = beat_data(r, (first + f) & 16'hFFFF);
                b.last = (r == 7);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: a beat with TVALID & TREADY at the falling edge is accepted on the next rising edge.
    logic          prev_stall[2];
    logic [DW-1:0] prev_data[2];
    logic          prev_last[2];
    logic          after_last[2];
    int            gap_cnt[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_stall[i] = 1'b0;
            prev_data[i]  = '0;
            prev_last[i]  = 1'b0;
            after_last[i] = 1'b0;
            gap_cnt[i]    = 0;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                prev_stall[i] = 1'b0;
                after_last[i] = 1'b0;
            end else begin
                if (prev_stall[i]) begin
                    checks++;
                    if (tvalid_m[i] !== 1'b1 || tdata_m[i] !== prev_data[i] || tlast_m[i] !== prev_last[i]) begin
                        errors++;
                        $display("FAIL stable dut%0d: tvalid=%b tlast=%b tdata=%h, required tvalid=1 tlast=%b tdata=%h",
                                 i, tvalid_m[i], tlast_m[i], tdata_m[i][31:0], prev_last[i], prev_data[i][31:0]);
                    end
                end
                if (after_last[i]) begin
                    if (tvalid_m[i]) begin
                        checks++;
                        if (gap_cnt[i] != gap_exp(i)) begin
                            errors++;
                            $display("FAIL gap dut%0d: idle cycles %0d, required %0d", i, gap_cnt[i], gap_exp(i));
                        end
                        after_last[i] = 1'b0;
                    end else if (!busy_m[i]) begin
                        after_last[i] = 1'b0;
                    end else begin
                        gap_cnt[i]++;
                    end
                end
                if (tvalid_m[i] && tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat dut%0d: unexpected beat tdata=%h tlast=%b, required no beat",
                                 i, tdata_m[i][31:0], tlast_m[i]);
                    end else begin
                        b = exp_q.pop_front();
                        if (b.id != i || tdata_m[i] !== b.data || tlast_m[i] !== b.last) begin
                            errors++;
                            $display("FAIL beat dut%0d: tdata=%h tlast=%b, required dut%0d tdata=%h tlast=%b",
                                     i, tdata_m[i][31:0], tlast_m[i], b.id, b.data[31:0], b.last);
                        end
                    end
                    if (tlast_m[i]) begin
                        after_last[i] = 1'b1;
                        gap_cnt[i]    = 0;
                    end
                end
                prev_stall[i] = tvalid_m[i] && !tready;
                prev_data[i]  = tdata_m[i];
                prev_last[i]  = tlast_m[i];
            end
        end
    end

    task automatic pulse(input int i);
        @(posedge clk); #1;
        if (i == 0) button_a = 1'b1; else button_g = 1'b1;
        @(posedge clk); #1;
        if (i == 0) button_a = 1'b0; else button_g = 1'b0;
    endtask

    task automatic run_until_idle(input int i, input bit rnd, input int budget,
                                  output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        while (cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (rnd) tready = 1'($urandom_range(0, 1));
            if (!busy_m[i]) begin
                timed_out = 1'b0;
                break;
            end
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        button_a    = 1'b1;
        button_g    = 1'b0;
        stop        = 1'b0;
        tready      = 1'b1;
        frame_count = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || busy_a !== 1'b0 || tdata_a !== beat_data(0, 12)) begin
            errors++;
            $display("FAIL reset_a: tvalid=%b tlast=%b busy=%b tdata=%h, required 0 0 0 %h",
                     tvalid_a, tlast_a, busy_a, tdata_a[31:0], beat_data(0, 12) & 32'hFFFFFFFF);
        end
        checks++;
        if (tvalid_g !== 1'b0 || tlast_g !== 1'b0 || busy_g !== 1'b0 || tdata_g !== beat_data(0, 16'hFFFF)) begin
            errors++;
            $display("FAIL reset_g: tvalid=%b tlast=%b busy=%b tdata=%h, required 0 0 0 ffff0000",
                     tvalid_g, tlast_g, busy_g, tdata_g[31:0]);
        end
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (busy_a !== 1'b0 || tvalid_a !== 1'b0) begin
                errors++;
                $display("FAIL held_button: busy=%b tvalid=%b, required 0 0", busy_a, tvalid_a);
            end
        end
        button_a = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_single();
        int cyc;
        bit to;
        frame_count = 8'd1;
        push_frames(0, 12, 1);
        pulse(0);
        checks++;
        if (tvalid_a !== 1'b1 || busy_a !== 1'b1 || tdata_a !== beat_data(0, 12) || tlast_a !== 1'b0) begin
            errors++;
            $display("FAIL latency: tvalid=%b busy=%b tlast=%b tdata=%h, required 1 1 0 000c0000",
                     tvalid_a, busy_a, tlast_a, tdata_a[31:0]);
        end
        run_until_idle(0, 1'b0, 100, cyc, to);
        checks++;
        if (to || cyc != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single: cycles=%0d timeout=%b left=%0d, required 8 0 0", cyc, to, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        frame_count = 8'd2;
        push_frames(0, 13, 2);
        pulse(0);
        run_until_idle(0, 1'b0, 100, cyc, to);
        checks++;
        if (to || cyc != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: cycles=%0d timeout=%b left=%0d, required 16 0 0", cyc, to, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit to;
        frame_count = 8'd2;
        push_frames(0, 15, 2);
        pulse(0);
        run_until_idle(0, 1'b1, 1000, cyc, to);
        checks++;
        if (to || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure: timeout=%b left=%0d, required 0 0", to, exp_q.size());
        end
    endtask

    task automatic test_stop();
        int cyc;
        bit to;
        frame_count = 8'd0;
        push_frames(0, 17, 5);
        pulse(0);
        cyc = 0;
        to  = 1'b1;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (tvalid_a && tdata_a[7:0] == 8'd3 && tdata_a[31:16] == 16'd21) stop = 1'b1;
            if (!busy_a) begin
                to = 1'b0;
                break;
            end
        end
        stop = 1'b0;
        checks++;
        if (to || cyc != 40 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stop: cycles=%0d timeout=%b left=%0d, required 40 0 0", cyc, to, exp_q.size());
        end
    endtask

    task automatic test_wrap_ignore();
        int cyc;
        bit to;
        frame_count = 8'd2;
        push_frames(1, 16'hFFFF, 2);
        pulse(1);
        repeat (4) @(posedge clk);
        #1 button_g = 1'b1;
        @(posedge clk);
        #1 button_g = 1'b0;
        run_until_idle(1, 1'b0, 100, cyc, to);
        checks++;
        if (to || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: timeout=%b left=%0d, required 0 0", to, exp_q.size());
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy_g !== 1'b0 || tvalid_g !== 1'b0) begin
            errors++;
            $display("FAIL ignored_edge: busy=%b tvalid=%b, required 0 0", busy_g, tvalid_g);
        end
    endtask

    task automatic test_gap();
        int cyc;
        bit to;
        frame_count = 8'd3;
        push_frames(1, 1, 3);
        pulse(1);
        run_until_idle(1, 1'b0, 100, cyc, to);
        checks++;
        if (to || cyc != 28 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gap_run: cycles=%0d timeout=%b left=%0d, required 28 0 0", cyc, to, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        frame_count = 8'd1;
        push_frames(0, 22, 1);
        pulse(0);
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        button_a = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        checks++;
        if (tvalid_a !== 1'b0 || tlast_a !== 1'b0 || busy_a !== 1'b0 || tdata_a !== beat_data(0, 12)) begin
            errors++;
            $display("FAIL reset_mid: tvalid=%b tlast=%b busy=%b tdata=%h, required 0 0 0 000c0000",
                     tvalid_a, tlast_a, busy_a, tdata_a[31:0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (busy_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_held: busy=%b, required 0", busy_a);
            end
        end
        button_a = 1'b0;
        @(posedge clk);
        push_frames(0, 12, 1);
        pulse(0);
        run_until_idle(0, 1'b0, 100, cyc, to);
        checks++;
        if (to || cyc != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart: cycles=%0d timeout=%b left=%0d, required 8 0 0", cyc, to, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stop();
        test_wrap_ignore();
        test_gap();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/frame_request_gen.md
# frame_request_gen

Parametrised successor to the single-burst row request generator. On a trigger it emits one or more frames of row-request beats on an AXI-Stream master, marking the last row of each frame with TLAST and advancing a wrapping frame number between frames. It adds runtime frame count, continuous mode, graceful stop and an inter-frame gap. It sits between the board trigger (button or control register) and the request consumer.

## Interface
- DATA_WIDTH, 256: TDATA width; must be ≥ 32.
- ROWS_PER_FRAME, 8: beats per frame; range 1..256.
- FIRST_FRAME, 12: frame number loaded at reset.
- GAP_CYCLES, 0: idle cycles between consecutive frames of one run; range 0..255.

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- BUTTON  in  1  trigger level; only a rising edge starts a run.
- FRAME_COUNT  in  8  frames per run, sampled at run start; 0 = continuous.
- STOP  in  1  level; ends a run at the next frame boundary.
- BUSY  out  1  high from run start until the last beat of the run is accepted.
- AXIS_TX_TDATA  out  DATA_WIDTH  [7:0] row, [31:16] frame, all other bits 0.
- AXIS_TX_TVALID  out  1  beat valid.
- AXIS_TX_TLAST  out  1  high on the last row of each frame.
- AXIS_TX_TREADY  in  1  consumer ready.

## Operation
- States: IDLE, SEND, GAP.
- Reset: state IDLE; TVALID 0, TLAST 0, BUSY 0; row 0; frame FIRST_FRAME; frames_left 0; BUTTON history cleared to 0 (button held high through reset does not trigger).
- IDLE: rising edge (BUTTON=1, registered BUTTON=0) → SEND; latch FRAME_COUNT into frames_left; row 0; TVALID 1; TLAST = (ROWS_PER_FRAME==1); BUSY 1. Frame is NOT reset: it continues from its last value.
- SEND, beat accepted (TVALID & TREADY), row < ROWS_PER_FRAME-1: row+1; TLAST 1 if new row is last.
- SEND, last beat accepted: frame+1 (16-bit wrap 0xFFFF→0); row 0; decrement frames_left unless continuous. Run ends if STOP=1 in that cycle, or (not continuous and frames_left was 1): TVALID 0, TLAST 0, BUSY 0, → IDLE. Otherwise GAP_CYCLES=0: next frame's first beat presented the following cycle (TVALID stays 1); GAP_CYCLES>0: TVALID 0, → GAP.
- GAP: count GAP_CYCLES cycles with TVALID 0, then → SEND with TVALID 1. STOP seen in GAP → IDLE immediately, BUSY 0.
- STOP mid-frame does not truncate the frame; frames are always complete.
- BUTTON edges while BUSY are ignored and not queued.

## Timing
- Trigger latency: edge sampled at clock n → TVALID 1 at n+1.
- AXI rules: once TVALID is 1, TVALID, TDATA and TLAST hold stable until accepted; TVALID never depends on TREADY combinationally.
- Back-to-back throughput with TREADY held 1 and GAP_CYCLES=0: one beat per clock across frame boundaries.
- Gap: exactly GAP_CYCLES cycles with TVALID 0 between last-beat accept and next first beat.
- Reset mid-run: next cycle all outputs at reset values; partial frame abandoned, no TLAST emitted.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package frame_req_pkg: state enum (IDLE, SEND, GAP), TDATA field offsets/widths (ROW_LSB 0, ROW_W 8, FRAME_LSB 16, FRAME_W 16).
- Sub-module rise_detect: one-flop rising-edge detector for BUTTON, reset-cleared.
- Elaboration check: DATA_WIDTH ≥ 32, ROWS_PER_FRAME in 1..256, GAP_CYCLES ≤ 255.

## Test plan
- Defaults, FRAME_COUNT=1, TREADY=1, one BUTTON pulse → 8 beats rows 0..7, frame 12, TLAST only on row 7; BUSY falls after; frame register 13.
- FRAME_COUNT=3, GAP_CYCLES=2, TREADY=1 → 24 beats, frames 12,13,14, exactly 2 idle cycles between frames, 3 TLASTs.
- Random TREADY backpressure → TDATA/TLAST stable while TVALID & !TREADY; row sequence unbroken, no beat lost or duplicated.
- FRAME_COUNT=0, STOP asserted on row 3 of the fifth frame → that frame completes through row 7 with TLAST, then IDLE; total 40 beats.
- Preset frame 0xFFFF, FRAME_COUNT=2 → frames 0xFFFF then 0x0000; extra BUTTON edge during run ignored.
- Reset asserted mid-frame with BUTTON held high → TVALID 0 next cycle, frame 12; no run starts until BUTTON drops and rises again.
